// File: rtl/mem_bus_fabric_if.sv
// ---------------------------------------------------------------------------
// mem_bus_fabric_if
// Bundles the picorv32 native memory port and the per-slave select/ready/
// read-data lines that the fabric sits between.
//   mem_valid/mem_addr/mem_wstrb : core request
//   mem_ready/mem_rdata          : completion back to the core
//   slv_sel                      : one-hot slave select
//   slv_ready/slv_rdata          : per-slave ready and flattened read data
// The slave modport is the fabric's view; master is the core+slaves view.
// ---------------------------------------------------------------------------
interface mem_bus_fabric_if #(
    parameter int unsigned NSLAVES = 4
);
    logic                    mem_valid;
    logic [31:0]             mem_addr;
    logic [3:0]              mem_wstrb;
    logic                    mem_ready;
    logic [31:0]             mem_rdata;
    logic [NSLAVES-1:0]      slv_sel;
    logic [NSLAVES-1:0]      slv_ready;
    logic [32*NSLAVES-1:0]   slv_rdata;

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, slv_ready, slv_rdata,
        output mem_ready, mem_rdata, slv_sel
    );

    modport master (
        output mem_valid, mem_addr, mem_wstrb, slv_ready, slv_rdata,
        input  mem_ready, mem_rdata, slv_sel
    );
endinterface

// File: rtl/mem_bus_fabric.sv
// ---------------------------------------------------------------------------
// mem_bus_fabric
// Address decoder and response mux between the picorv32 memory port and
// NSLAVES memory-mapped slaves. Unmapped addresses and slaves that stay
// silent for TIMEOUT cycles complete with ERR_DATA; sticky error status is
// kept for software/debug.
// Ports:
//   clk, reset_n    : clock, synchronous active-low reset
//   bus             : mem_bus_fabric_if.slave (core port + slave lines)
//   err_clr         : clears err_flag and err_count
//   err_flag        : sticky error seen since last clear
//   err_timeout     : last error cause (1 = timeout, 0 = unmapped)
//   err_write       : last errored access was a write
//   err_addr        : address of last errored access
//   err_count       : saturating error count
// ---------------------------------------------------------------------------
module mem_bus_fabric #(
    parameter int unsigned          NSLAVES    = 4,
    parameter logic [32*NSLAVES-1:0] SLAVE_BASE =
        {32'h80000010, 32'h80000008, 32'h80000000, 32'h00000000},
    parameter logic [32*NSLAVES-1:0] SLAVE_MASK =
        {32'hffffffff, 32'hfffffff8, 32'hffffffff, 32'hffffe000},
    parameter int unsigned          TIMEOUT    = 256,
    parameter logic [31:0]          ERR_DATA   = 32'hdeadbeef
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_bus_fabric_if.slave     bus,
    input  logic                err_clr,
    output logic                err_flag,
    output logic                err_timeout,
    output logic                err_write,
    output logic [31:0]         err_addr,
    output logic [7:0]          err_count
);
    localparam int unsigned IW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam logic [NSLAVES-1:0] ONE = NSLAVES'(1);
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_flag_q, err_flag_d;
    logic        err_timeout_q, err_timeout_d;
    logic        err_write_q, err_write_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic [7:0]  err_count_q, err_count_d;

    logic          hit_any;
    logic [IW-1:0] hit_idx;
    logic [31:0]   hit_rdata;
    logic          sel_active;
    logic          ready;
    logic          err_enter;
    logic          err_is_timeout;

    // Priority decode: the first matching slave in index order wins.
    always_comb begin
        hit_any   = 1'b0;
        hit_idx   = '0;
        hit_rdata = '0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (!hit_any &&
                ((bus.mem_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32])) begin
                hit_any   = 1'b1;
                hit_idx   = i[IW-1:0];
                hit_rdata = bus.slv_rdata[32*i +: 32];
            end
        end
    end

    // Select is withheld in the ERR cycle so no slave sees the errored access.
    always_comb begin
        sel_active  = bus.mem_valid & reset_n & hit_any & (state_q != ST_ERR);
        bus.slv_sel = sel_active ? (ONE << hit_idx) : '0;
        ready       = reset_n & ((state_q == ST_ERR) | (|(bus.slv_sel & bus.slv_ready)));
        bus.mem_ready = ready;
        if (!reset_n) begin
            bus.mem_rdata = '0;
        end else if (state_q == ST_ERR) begin
            bus.mem_rdata = ERR_DATA;
        end else if (sel_active) begin
            bus.mem_rdata = hit_rdata;
        end else begin
            bus.mem_rdata = '0;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        err_enter      = 1'b0;
        err_is_timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.mem_valid && !ready) begin
                    if (!hit_any) begin
                        state_d   = ST_ERR;
                        err_enter = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = 16'd1;
                    end
                end
            end
            ST_BUSY: begin
                if (!bus.mem_valid || ready) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d        = ST_ERR;
                    cnt_d          = '0;
                    err_enter      = 1'b1;
                    err_is_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // An error entry takes priority over a coincident clear, so the clear
    // is folded in as a restart of the count from zero.
    always_comb begin
        err_flag_d    = err_flag_q;
        err_count_d   = err_count_q;
        err_addr_d    = err_addr_q;
        err_write_d   = err_write_q;
        err_timeout_d = err_timeout_q;
        if (err_enter) begin
            err_flag_d    = 1'b1;
            err_addr_d    = bus.mem_addr;
            err_write_d   = |bus.mem_wstrb;
            err_timeout_d = err_is_timeout;
            if (err_clr) begin
                err_count_d = 8'd1;
            end else if (err_count_q != 8'hff) begin
                err_count_d = err_count_q + 8'd1;
            end
        end else if (err_clr) begin
            err_flag_d  = 1'b0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            err_flag_q    <= 1'b0;
            err_count_q   <= '0;
            err_addr_q    <= '0;
            err_write_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            err_flag_q    <= err_flag_d;
            err_count_q   <= err_count_d;
            err_addr_q    <= err_addr_d;
            err_write_q   <= err_write_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_flag    = err_flag_q;
    assign err_count   = err_count_q;
    assign err_addr    = err_addr_q;
    assign err_write   = err_write_q;
    assign err_timeout = err_timeout_q;
endmodule

// File: tb/tb_mem_bus_fabric.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_fabric
// Scoreboard bench: each issued access pushes its expected completion
// (latency, read data, select, error status) and a monitor compares it
// whenever mem_ready is seen. Address map and error rules are modelled as
// plain address ranges and counters.
// ---------------------------------------------------------------------------
module tb_mem_bus_fabric;
    localparam int unsigned NS = 4;
    localparam int TO = 8;
    localparam logic [31:0] ERRD = 32'hdeadbeef;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_flag, err_timeout, err_write;
    logic [31:0] err_addr;
    logic [7:0]  err_count;

    mem_bus_fabric_if #(.NSLAVES(NS)) bus ();

    mem_bus_fabric #(
        .NSLAVES (NS),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .err_clr     (err_clr),
        .err_flag    (err_flag),
        .err_timeout (err_timeout),
        .err_write   (err_write),
        .err_addr    (err_addr),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic        flag;
        logic [7:0]  count;
        logic [31:0] addr;
        logic        wr;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tcyc = 0;

    // reference error status
    logic        m_flag = 0;
    logic [7:0]  m_count = 0;
    logic [31:0] m_addr = 0;
    logic        m_wr = 0;
    logic        m_tmo = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Address map: SRAM 0..0x1fff, slot 0x80000000, 8-byte UART window at
    // 0x80000008, single word at 0x80000010.
    function automatic int region(input logic [31:0] a);
        if (a < 32'h2000) return 0;
        if (a == 32'h80000000) return 1;
        if (a >= 32'h80000008 && a <= 32'h8000000f) return 2;
        if (a == 32'h80000010) return 3;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (reset_n && bus.mem_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_ready: got 1 expected 0 at t=%0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency",     tcyc,          e.lat);
                chk("rdata",       bus.mem_rdata, e.rdata);
                chk("sel",         {28'd0, bus.slv_sel}, {28'd0, e.sel});
                chk("err_flag",    {31'd0, err_flag},    {31'd0, e.flag});
                chk("err_count",   {24'd0, err_count},   {24'd0, e.count});
                chk("err_addr",    err_addr,             e.addr);
                chk("err_write",   {31'd0, err_write},   {31'd0, e.wr});
                chk("err_timeout", {31'd0, err_timeout}, {31'd0, e.tmo});
            end
        end
    end

    // Entered and left at posedge+1.
    task automatic do_txn(input logic [31:0] a, input logic [3:0] ws,
                          input int dly, input bit clr_at_err);
        int          tgt;
        logic [3:0]  tmask;
        logic [31:0] data[NS];
        logic [3:0]  sp;
        bit          iserr, done;
        exp_t        e;
        tgt = region(a);
        tmask = (tgt >= 0) ? (4'b0001 << tgt) : 4'b0000;
        for (int k = 0; k < NS; k++) data[k] = $urandom;
        bus.slv_rdata = {data[3], data[2], data[1], data[0]};
        iserr = 0;
        if (tgt < 0) begin
            e.lat = 1; iserr = 1; m_tmo = 0;
        end else if (dly < 0) begin
            e.lat = TO; iserr = 1; m_tmo = 1;
        end else begin
            e.lat = dly;
        end
        if (iserr) begin
            m_flag = 1;
            m_addr = a;
            m_wr = (ws != 4'd0);
            if (clr_at_err) m_count = 8'd1;
            else if (m_count != 8'd255) m_count = m_count + 8'd1;
            e.rdata = ERRD;
            e.sel = 4'b0000;
        end else begin
            e.rdata = data[tgt];
            e.sel = tmask;
        end
        e.flag = m_flag; e.count = m_count; e.addr = m_addr; e.wr = m_wr; e.tmo = m_tmo;
        exp_q.push_back(e);
        done = 0;
        for (int c = 0; c <= TO + 4; c++) begin
            tcyc = c;
            bus.mem_valid = 1'b1;
            bus.mem_addr = a;
            bus.mem_wstrb = ws;
            sp = 4'($urandom);
            if (c == 1) sp = 4'hf;
            bus.slv_ready = (sp & ~tmask) | ((tgt >= 0 && c == dly) ? tmask : 4'b0000);
            err_clr = clr_at_err && iserr && (c == e.lat - 1);
            @(negedge clk);
            done = bus.mem_ready;
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) begin
            errors++;
            checks++;
            $display("FAIL txn_bound: addr %h got no ready expected ready by cycle %0d", a, e.lat);
            exp_q.delete();
        end
        bus.mem_valid = 1'b0;
        bus.slv_ready = '0;
        bus.mem_wstrb = '0;
        err_clr = 1'b0;
    endtask

    task automatic clr_only();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        m_flag = 0;
        m_count = 0;
        @(negedge clk);
        chk("clr_flag",    {31'd0, err_flag},    {31'd0, m_flag});
        chk("clr_count",   {24'd0, err_count},   {24'd0, m_count});
        chk("clr_addr",    err_addr,             m_addr);
        chk("clr_write",   {31'd0, err_write},   {31'd0, m_wr});
        chk("clr_timeout", {31'd0, err_timeout}, {31'd0, m_tmo});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_ready"},   {31'd0, bus.mem_ready}, 32'd0);
        chk({tag, "_sel"},     {28'd0, bus.slv_sel},   32'd0);
        chk({tag, "_rdata"},   bus.mem_rdata,          32'd0);
        chk({tag, "_flag"},    {31'd0, err_flag},      32'd0);
        chk({tag, "_count"},   {24'd0, err_count},     32'd0);
        chk({tag, "_addr"},    err_addr,               32'd0);
        chk({tag, "_write"},   {31'd0, err_write},     32'd0);
        chk({tag, "_timeout"}, {31'd0, err_timeout},   32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          r, dly;
        bus.mem_valid = 0;
        bus.mem_addr = 0;
        bus.mem_wstrb = 0;
        bus.slv_ready = 0;
        bus.slv_rdata = 0;
        idle(3);
        // Valid during reset must not produce a select or ready.
        bus.mem_valid = 1'b1;
        bus.slv_ready = 4'hf;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_sel",   {28'd0, bus.slv_sel},   32'd0);
        @(posedge clk);
        #1;
        bus.mem_valid = 1'b0;
        bus.slv_ready = '0;
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;

        do_txn(32'h00001ffc, 4'h0, 0, 0);   // SRAM, zero-latency
        idle(1);
        do_txn(32'h8000000c, 4'h0, 3, 0);   // UART slot, spurious ready on others
        idle(1);
        do_txn(32'h40000000, 4'hf, 0, 0);   // unmapped write
        idle(1);
        do_txn(32'h80000000, 4'h0, -1, 0);  // silent slave -> timeout
        do_txn(32'h80000010, 4'h3, 2, 0);   // next access completes normally
        idle(1);
        do_txn(32'h80000008, 4'h0, TO - 1, 0); // ready on the last legal cycle
        for (int i = 0; i < 300; i++) do_txn(32'h40000000 + 32'(i), 4'(i), 0, 0);
        do_txn(32'h20000000, 4'h0, 0, 1);   // clear coincident with error
        idle(1);
        clr_only();

        // Reset abandons a BUSY access: assert reset in cycle 3.
        bus.mem_valid = 1'b1;
        bus.mem_addr = 32'h80000000;
        bus.slv_ready = '0;
        idle(3);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("midrst_sel",   {28'd0, bus.slv_sel},   32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.mem_valid = 1'b0;
        m_flag = 0; m_count = 0; m_addr = 0; m_wr = 0; m_tmo = 0;
        @(negedge clk);
        check_quiet("postrst");
        @(posedge clk);
        #1;
        do_txn(32'h00000100, 4'h0, 1, 0);

        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: a = 32'($urandom) & 32'h00001ffc;
                1: a = 32'h80000000;
                2: a = 32'h80000008 + 32'($urandom_range(0, 7));
                3: a = 32'h80000010;
                4: a = 32'h80000014 + 32'($urandom_range(0, 255));
                default: a = 32'($urandom) | 32'h00002000;
            endcase
            dly = ($urandom_range(0, 5) == 0) ? -1 : $urandom_range(0, TO - 1);
            do_txn(a, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, dly,
                   $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) clr_only();
            else idle($urandom_range(0, 2));
        end

        idle(2);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
